// File: rtl/block_feeder_pkg.sv
// block_feeder_pkg
//   Shared cipher-side definitions: word/block geometry, the feeder FSM
//   state encoding and a small packing helper used by the 32->128 packers.
package block_feeder_pkg;

  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;
  localparam int BLK_W         = WORD_W * WORDS_PER_BLK;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_BLK,
    START,
    RUN,
    DRAIN
  } feeder_state_e;

  typedef logic [$clog2(WORDS_PER_BLK)-1:0] word_cnt_t;

  localparam word_cnt_t LAST_WORD = word_cnt_t'(WORDS_PER_BLK - 1);

  // Shift a new word in at the bottom; after four pushes the first word
  // sits in the top slot, giving big-endian word order.
  function automatic logic [BLK_W-1:0] push_word(input logic [BLK_W-1:0]  acc,
                                                 input logic [WORD_W-1:0] word);
    return {acc[BLK_W-WORD_W-1:0], word};
  endfunction

endpackage

// File: rtl/block_feeder_if.sv
// block_feeder_if
//   Word-stream side of the block feeder.
//   in_data/in_valid/in_ready : 32-bit input stream (key words, block words)
//   in_newkey/in_ende         : operation attributes, meaningful on first beat
//   out_data/out_valid/out_ready/out_last : 32-bit result stream
//   slave  : seen by the feeder
//   master : seen by whatever drives the stream
interface block_feeder_if;
  import block_feeder_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              in_newkey;
  logic              in_ende;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport slave (
    input  in_data, in_valid, in_newkey, in_ende, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, in_newkey, in_ende, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/block_feeder.sv
// block_feeder
//   Collects an optional 128-bit key and a 128-bit block from a 32-bit word
//   stream, launches the cipher datapath, waits for its result and streams
//   it back out as four 32-bit words. Aborts with a sticky err if the
//   datapath does not finish within TIMEOUT cycles.
// Ports
//   Clk       : clock, rising edge
//   Reset_n   : asynchronous active-low reset
//   bus       : word-stream interface (slave side)
//   dp_block  : block to datapath, first input word in [127:96]
//   dp_key    : key to datapath, retained across operations without newkey
//   dp_start  : start request, high for every START cycle
//   dp_ende   : 0 encrypt / 1 decrypt, held for the operation
//   dp_o      : datapath result
//   dp_busy   : datapath busy
//   err       : sticky timeout flag
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for first beat; latches newkey/ende
// LOAD_KEY | collecting key words 1..3
// LOAD_BLK | collecting remaining block words
// START    | dp_start high until datapath reports busy
// RUN      | datapath busy; result captured when busy drops
// DRAIN    | streaming the 4 result words out
module block_feeder
  import block_feeder_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  block_feeder_if.slave    bus,
  output logic [BLK_W-1:0] dp_block,
  output logic [BLK_W-1:0] dp_key,
  output logic             dp_start,
  output logic             dp_ende,
  input  logic [BLK_W-1:0] dp_o,
  input  logic             dp_busy,
  output logic             err
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  feeder_state_e    state, state_nxt;
  word_cnt_t        word_cnt;
  logic [TIMER_W-1:0] timer;
  logic [BLK_W-1:0] shift_q;
  logic             accept;
  logic             in_beat;
  logic             out_beat;
  logic             timer_done;
  logic             abort;
  logic             capture;

  assign in_beat    = bus.in_valid && accept;
  assign out_beat   = bus.out_ready && (state == DRAIN);
  assign timer_done = (timer == '0);

  // Completion wins over timeout when both land in the same cycle.
  assign capture = (state == RUN) && !dp_busy;
  assign abort   = timer_done &&
                   (((state == START) && !dp_busy) || ((state == RUN) && dp_busy));

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_beat) begin
          state_nxt = bus.in_newkey ? LOAD_KEY : LOAD_BLK;
        end
      end
      LOAD_KEY: begin
        if (in_beat && (word_cnt == LAST_WORD)) begin
          state_nxt = LOAD_BLK;
        end
      end
      LOAD_BLK: begin
        if (in_beat && (word_cnt == LAST_WORD)) begin
          state_nxt = START;
        end
      end
      START: begin
        if (dp_busy) begin
          state_nxt = RUN;
        end else if (timer_done) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (!dp_busy) begin
          state_nxt = DRAIN;
        end else if (timer_done) begin
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (out_beat && (word_cnt == LAST_WORD)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    accept        = 1'b0;
    dp_start      = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    unique case (state)
      IDLE, LOAD_KEY, LOAD_BLK: accept = 1'b1;
      START:                    dp_start = 1'b1;
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (word_cnt == LAST_WORD);
      end
      default: ;
    endcase
  end

  assign bus.in_ready = accept;
  assign bus.out_data = shift_q[BLK_W-1 -: WORD_W];

  // packers, word counter, result shifter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      word_cnt <= '0;
      dp_key   <= '0;
      dp_block <= '0;
      dp_ende  <= 1'b0;
      shift_q  <= '0;
    end else begin
      // Load and drain never overlap, so one counter serves both; it
      // wraps to 0 on the 4th word, ready for the next phase.
      if (in_beat || out_beat) begin
        word_cnt <= word_cnt + word_cnt_t'(1);
      end

      if (in_beat && (state == IDLE)) begin
        dp_ende <= bus.in_ende;
      end

      if (in_beat && ((state == LOAD_KEY) || ((state == IDLE) && bus.in_newkey))) begin
        dp_key <= push_word(dp_key, bus.in_data);
      end

      if (in_beat && ((state == LOAD_BLK) || ((state == IDLE) && !bus.in_newkey))) begin
        dp_block <= push_word(dp_block, bus.in_data);
      end

      if (capture) begin
        shift_q <= dp_o;
      end else if (out_beat) begin
        shift_q <= {shift_q[BLK_W-WORD_W-1:0], {WORD_W{1'b0}}};
      end
    end
  end

  // START+RUN watchdog: down-counter loaded on entry to START
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timer <= '0;
      err   <= 1'b0;
    end else begin
      if ((state == LOAD_BLK) && (state_nxt == START)) begin
        timer <= TIMER_W'(TIMEOUT - 1);
      end else if (((state == START) || (state == RUN)) && !timer_done) begin
        timer <= timer - TIMER_W'(1);
      end

      if (abort) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_block_feeder.sv
// tb_block_feeder
//   Randomised stream bench for block_feeder with a stand-in datapath:
//   result = block ^ key ^ K0. K0 is chosen so the all-zero key/block
//   encrypt vector and its decrypt inverse reproduce the reference words.
module tb_block_feeder;
  import block_feeder_pkg::*;

  localparam int          TO = 16;
  localparam logic [127:0] K0 = 128'h9F589F5C_F6122C32_B6BFEC2F_2AE8C35A;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic [127:0] dp_block, dp_key, dp_o;
  logic         dp_start, dp_ende, dp_busy, err;

  block_feeder_if bus ();

  block_feeder #(.TIMEOUT(TO)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus),
    .dp_block(dp_block),
    .dp_key  (dp_key),
    .dp_start(dp_start),
    .dp_ende (dp_ende),
    .dp_o    (dp_o),
    .dp_busy (dp_busy),
    .err     (err)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] model_key;
  bit           stub_dead = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // stand-in datapath: random latency before busy, random busy length
  int           stub_ph;
  int           stub_cnt;
  logic [127:0] stub_res;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      stub_ph  <= 0;
      stub_cnt <= 0;
      stub_res <= '0;
      dp_busy  <= 1'b0;
      dp_o     <= '0;
    end else begin
      case (stub_ph)
        0: if (dp_start && !stub_dead) begin
          stub_res <= dp_block ^ dp_key ^ K0;
          stub_cnt <= int'($urandom_range(0, 3));
          stub_ph  <= 1;
        end
        1: if (stub_cnt == 0) begin
          dp_busy  <= 1'b1;
          dp_o     <= {$urandom(), $urandom(), $urandom(), $urandom()};
          stub_cnt <= int'($urandom_range(1, 6));
          stub_ph  <= 2;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
        default: if (stub_cnt == 1) begin
          dp_busy <= 1'b0;
          dp_o    <= stub_res;
          stub_ph <= 0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      endcase
    end
  end

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [31:0] w, input logic nk, input logic ed);
    int budget = 0;
    repeat ($urandom_range(0, 2)) begin
      bus.in_valid = 1'b0;
      @(negedge Clk);
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = w;
    bus.in_newkey = nk;
    bus.in_ende   = ed;
    while (!bus.in_ready && budget < 100) begin
      @(negedge Clk);
      budget++;
    end
    if (!bus.in_ready) begin
      check_val("in_ready_wait", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge Clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_op(input logic nk, input logic ed, input logic [127:0] key,
                         input logic [127:0] blk, input int n_words);
    logic [255:0] stream;
    stream = {key, blk};
    for (int i = 0; i < n_words; i++) begin
      int base;
      base = nk ? i : i + 4;
      if (i == 0) send_word(stream[255-32*base -: 32], nk, ed);
      else        send_word(stream[255-32*base -: 32], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if (nk) model_key = key;
  endtask

  // mode 0: out_ready always high, 1: random stalls, 2: 10-cycle stall on word 1
  task automatic recv_block(input logic [127:0] blk, input logic ed, input int mode);
    logic [127:0] res;
    logic [31:0]  ew;
    int           budget = 0;
    bit           seen_start = 0;
    int           stall;
    while (!bus.out_valid && budget < 100) begin
      if (dp_start && !seen_start) begin
        seen_start = 1;
        check_val("dp_block", dp_block, blk);
        check_val("dp_key", dp_key, model_key);
        check_val("dp_ende", dp_ende, ed);
      end
      @(negedge Clk);
      budget++;
    end
    check_val("start_seen", seen_start, 1);
    check_val("drain_reached", bus.out_valid, 1);
    if (!bus.out_valid) return;
    res = blk ^ model_key ^ K0;
    for (int i = 0; i < 4; i++) begin
      ew = res[127-32*i -: 32];
      stall = (mode == 2 && i == 1) ? 10 : (mode == 1 ? int'($urandom_range(0, 2)) : 0);
      bus.out_ready = 1'b0;
      if (stall == 10) begin
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom();
      end
      for (int s = 0; s < stall; s++) begin
        check_val("hold_data", bus.out_data, ew);
        check_val("hold_valid", bus.out_valid, 1);
        check_val("hold_in_ready", bus.in_ready, 0);
        @(negedge Clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check_val("out_valid", bus.out_valid, 1);
      check_val("out_data", bus.out_data, ew);
      check_val("out_last", bus.out_last, (i == 3));
      check_val("drain_in_ready", bus.in_ready, 0);
      @(negedge Clk);
    end
    bus.out_ready = 1'b0;
    check_val("ready_after_last", bus.in_ready, 1);
    check_val("valid_after_last", bus.out_valid, 0);
  endtask

  task automatic full_op(input logic nk, input logic ed, input logic [127:0] key,
                         input logic [127:0] blk, input int mode);
    send_op(nk, ed, key, blk, nk ? 8 : 4);
    recv_block(blk, ed, mode);
  endtask

  initial begin
    logic [127:0] rk, rb;
    int           n_start;
    int           budget;
    bit           saw_valid;

    Reset_n       = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_newkey = 1'b0;
    bus.in_ende   = 1'b0;
    bus.out_ready = 1'b0;
    model_key     = '0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    check_val("rst_in_ready", bus.in_ready, 1);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_last", bus.out_last, 0);
    check_val("rst_dp_start", dp_start, 0);
    check_val("rst_dp_key", dp_key, 0);
    check_val("rst_dp_block", dp_block, 0);
    check_val("rst_dp_ende", dp_ende, 0);
    check_val("rst_err", err, 0);

    // all-zero key and block, encrypt
    full_op(1'b1, 1'b0, '0, '0, 0);
    // reuse key, decrypt the reference ciphertext back to zero
    full_op(1'b0, 1'b1, '0, K0, 0);
    // long back-pressure in DRAIN with junk on the input side
    full_op(1'b0, 1'b0, '0, {$urandom(), $urandom(), $urandom(), $urandom()}, 2);

    for (int n = 0; n < 24; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      full_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rk, rb,
              int'($urandom_range(0, 1)));
    end
    check_val("err_before_timeout", err, 0);

    // datapath never answers
    stub_dead = 1'b1;
    send_op(1'b0, 1'b0, '0, {$urandom(), $urandom(), $urandom(), $urandom()}, 4);
    n_start   = 0;
    budget    = 0;
    saw_valid = 0;
    while (!bus.in_ready && budget < 100) begin
      if (dp_start) n_start++;
      if (bus.out_valid) saw_valid = 1;
      @(negedge Clk);
      budget++;
    end
    check_val("timeout_start_cycles", n_start, TO);
    check_val("timeout_err", err, 1);
    check_val("timeout_idle", bus.in_ready, 1);
    check_val("timeout_no_output", saw_valid, 0);
    check_val("timeout_dp_start", dp_start, 0);
    repeat (3) @(negedge Clk);
    check_val("err_sticky", err, 1);
    check_val("timeout_still_no_output", bus.out_valid, 0);
    stub_dead = 1'b0;

    // reset while LOAD_BLK word 2 is on the bus
    rk = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
    rb = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1;
    send_op(1'b1, 1'b1, rk, rb, 6);
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom();
    #2 Reset_n = 1'b0;
    #1;
    check_val("arst_dp_key", dp_key, 0);
    check_val("arst_dp_block", dp_block, 0);
    check_val("arst_dp_start", dp_start, 0);
    check_val("arst_dp_ende", dp_ende, 0);
    check_val("arst_out_valid", bus.out_valid, 0);
    check_val("arst_out_last", bus.out_last, 0);
    check_val("arst_out_data", bus.out_data, 0);
    check_val("arst_err", err, 0);
    check_val("arst_in_ready", bus.in_ready, 1);
    @(negedge Clk);
    bus.in_valid = 1'b0;
    Reset_n      = 1'b1;
    model_key    = '0;
    @(negedge Clk);
    full_op(1'b1, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()}, 1);
    check_val("post_reset_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/block_feeder.md
BLOCK_FEEDER -- requirements
Module: block_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles spent in START or RUN before abort.
REQ-002 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_data  in  32  input word; first accepted word maps to bits [127:96].
REQ-005 SHALL have port in_valid  in  1  input word valid.
REQ-006 SHALL have port in_ready  out  1  block can accept an input word.
REQ-007 SHALL have port in_newkey  in  1  sampled on first beat only; 1 = 4 key words precede 4 block words.
REQ-008 SHALL have port in_ende  in  1  sampled on first beat only; 0 = encrypt, 1 = decrypt.
REQ-009 SHALL have port dp_block  out  128  block to cipher datapath, big-endian word order.
REQ-010 SHALL have port dp_key  out  128  key to cipher datapath.
REQ-011 SHALL have port dp_start  out  1  Start to datapath.
REQ-012 SHALL have port dp_ende  out  1  EnDe to datapath, held for the whole operation.
REQ-013 SHALL have port dp_o  in  128  datapath result.
REQ-014 SHALL have port dp_busy  in  1  datapath busy.
REQ-015 SHALL have port out_data  out  32  result word, [127:96] first.
REQ-016 SHALL have port out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-017 SHALL have port out_last  out  1  high on the 4th result word.
REQ-018 SHALL have port err  out  1  sticky timeout flag.

Function
REQ-019 SHALL implement FSM IDLE, LOAD_KEY, LOAD_BLK, START, RUN, DRAIN.
REQ-020 SHALL transfer a word only when in_valid && in_ready, and an output word only when out_valid && out_ready.
REQ-021 SHALL assert in_ready only in IDLE, LOAD_KEY and LOAD_BLK.
REQ-022 SHALL, on the first beat in IDLE, latch in_newkey/in_ende and go to LOAD_KEY (newkey=1) or LOAD_BLK (newkey=0); that beat is key word 0 or block word 0.
REQ-023 SHALL use a 2-bit word counter wrapping 3->0; LOAD_KEY->LOAD_BLK after 4 key words; LOAD_BLK->START after 4 block words.
REQ-024 SHALL retain dp_key across operations when newkey=0; with no key ever loaded, dp_key is zero.
REQ-025 SHALL drive dp_start high in every START cycle, going to RUN (dp_start low) on the first cycle dp_busy=1.
REQ-026 SHALL, in RUN, on the first cycle dp_busy=0, capture dp_o into a 128-bit output shift register and enter DRAIN.
REQ-027 SHALL, in DRAIN, assert out_valid, shift 32 bits per accepted beat, hold data stable while out_ready=0, and return to IDLE after the 4th beat (out_last=1).
REQ-028 SHALL not accept new input in the cycle the last output beat transfers; in_ready rises the next cycle.
REQ-029 SHALL count cycles in START+RUN; at TIMEOUT, set err, drop dp_start, return to IDLE, produce no output.
REQ-030 SHALL ignore in_newkey/in_ende on non-first beats, and ignore in_valid while in_ready=0.

Reset
REQ-031 SHALL, on Reset_n low at any time including mid-operation, immediately force IDLE, counters 0, dp_key/dp_block/shift register 0, dp_start/out_valid/out_last/err 0, dp_ende 0.
REQ-032 SHALL leave datapath reset to the top level; the block does not drive it.

Structure
REQ-033 SHALL place the FSM state enum and the words-per-block constant (4) in the shared cipher package.
REQ-034 SHALL contain no sub-module; the 32->128 packer and 128->32 unpacker are inline registers.

Verification
REQ-035 SHALL check: newkey=1, ende=0, key=0, block=0 through real datapath -> out words 9F589F5C, F6122C32, B6BFEC2F, 2AE8C35A, out_last on the 4th.
REQ-036 SHALL check: newkey=0, ende=1, block=9F589F5C_F6122C32_B6BFEC2F_2AE8C35A -> output all-zero words, same key reused.
REQ-037 SHALL check: out_ready held 0 for 10 cycles in DRAIN -> out_data stable, no word lost, in_ready stays 0.
REQ-038 SHALL check: stub dp_busy never rising, TIMEOUT=16 -> err=1 after 16 START cycles, FSM back to IDLE, out_valid never asserted.
REQ-039 SHALL check: Reset_n pulsed low during LOAD_BLK word 2 -> all outputs zero at once; a fresh 8-beat transfer then completes correctly.
